// File: rtl/rv_test_mon_pkg.sv
// Shared types and constants for the ISA test signature monitor:
// FSM state encoding, default PASS/FAIL signatures and the register
// indices that carry the verdict (a7 = x17) and the failing case (a0 = x10).
package rv_test_mon_pkg;

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    ARMED        = 3'd1,
    DONE_PASS    = 3'd2,
    DONE_FAIL    = 3'd3,
    DONE_TIMEOUT = 3'd4
  } mon_state_e;

  localparam logic [31:0] DEF_PASS_SIG = 32'h0D00_0721;
  localparam logic [31:0] DEF_FAIL_SIG = 32'h0191_9810;

  localparam logic [4:0] REG_A0 = 5'd10;
  localparam logic [4:0] REG_A7 = 5'd17;

  // True for the absorbing verdict states.
  function automatic logic is_done_state(input mon_state_e s);
    return (s == DONE_PASS) || (s == DONE_FAIL) || (s == DONE_TIMEOUT);
  endfunction

endpackage

// File: rtl/rv_wb_shadow.sv
// Shadow copy of one architectural register, built by snooping the
// register-file writeback port. Writes to x0 never land, and the copy
// stops following the port once freeze_i is raised.
module rv_wb_shadow #(
  parameter logic [4:0] IDX = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        freeze_i,
  output logic [31:0] shadow_o
);

  logic [31:0] shadow_q;
  logic        take_s;

  assign take_s = wb_en_i && (wb_rd_i == IDX) && (IDX != 5'd0) && !freeze_i;

  // Capture the committed value of the tracked register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= 32'd0;
    end else if (take_s) begin
      shadow_q <= wb_data_i;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/rv_test_monitor.sv
// ISA test signature monitor. Watches the writeback port for a PASS or
// FAIL signature in x17, requires it to stay put for CONFIRM_CYCLES
// cycles, then latches a sticky verdict, the x10 value and the cycle count.
// Optional timeout verdict: define TEST_MON_TIMEOUT_EN.
module rv_test_monitor
  import rv_test_mon_pkg::*;
#(
  parameter logic [31:0] PASS_SIG       = DEF_PASS_SIG,
  parameter logic [31:0] FAIL_SIG       = DEF_FAIL_SIG,
  parameter int unsigned CONFIRM_CYCLES = 3,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CYC_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      fail_case,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned CNT_W       = $clog2(CONFIRM_CYCLES + 1) + 1;
  localparam logic        CONFIRM_ONE = (CONFIRM_CYCLES <= 32'd1);

  mon_state_e       state_q;
  logic [31:0]      sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic [31:0]      fail_case_q;
  logic [CYC_W-1:0] cycle_count_q;

  logic [31:0] a0_s;
  logic [31:0] a7_s;
  logic        freeze_s;
  logic        a7_is_sig_s;
  logic        a7_is_pass_s;
  logic        reached_s;
  logic        verdict_s;

  assign freeze_s     = is_done_state(state_q);
  assign a7_is_pass_s = (a7_s == PASS_SIG);
  assign a7_is_sig_s  = a7_is_pass_s || (a7_s == FAIL_SIG);
  assign reached_s    = (32'(cnt_q) + 32'd1) >= 32'(CONFIRM_CYCLES);

  rv_wb_shadow #(.IDX(REG_A0)) u_a0 (
    .clk       (clk),
    .rst       (rst),
    .wb_en_i   (wb_en),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .freeze_i  (freeze_s),
    .shadow_o  (a0_s)
  );

  rv_wb_shadow #(.IDX(REG_A7)) u_a7 (
    .clk       (clk),
    .rst       (rst),
    .wb_en_i   (wb_en),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .freeze_i  (freeze_s),
    .shadow_o  (a7_s)
  );

  // Decide whether this cycle confirms a PASS/FAIL verdict.
  always_comb begin
    verdict_s = 1'b0;
    case (state_q)
      RUN:     verdict_s = a7_is_sig_s && CONFIRM_ONE;
      ARMED:   verdict_s = (a7_s == sig_q) && reached_s;
      default: verdict_s = 1'b0;
    endcase
  end

`ifdef TEST_MON_TIMEOUT_EN
  logic timeout_q;
  logic timeout_hit_s;
  assign timeout_hit_s = (cycle_count_q == CYC_W'(TIMEOUT_CYCLES - 32'd1));
  assign timeout       = timeout_q;
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Monitor FSM with its registered verdict outputs and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      sig_q         <= 32'd0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_case_q   <= 32'd0;
      cycle_count_q <= '0;
`ifdef TEST_MON_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else if (!freeze_s) begin
      if (cycle_count_q != '1) begin
        cycle_count_q <= cycle_count_q + CYC_W'(1);
      end
      if (verdict_s) begin
        state_q     <= a7_is_pass_s ? DONE_PASS : DONE_FAIL;
        done_q      <= 1'b1;
        pass_q      <= a7_is_pass_s;
        fail_q      <= !a7_is_pass_s;
        fail_case_q <= a0_s;
      end
`ifdef TEST_MON_TIMEOUT_EN
      else if (timeout_hit_s) begin
        state_q     <= DONE_TIMEOUT;
        done_q      <= 1'b1;
        timeout_q   <= 1'b1;
        fail_case_q <= 32'd0;
      end
`endif
      else begin
        case (state_q)
          RUN: begin
            if (a7_is_sig_s) begin
              state_q <= ARMED;
              sig_q   <= a7_s;
              cnt_q   <= CNT_W'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          ARMED: begin
            if (a7_s == sig_q) begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end else if (a7_is_sig_s) begin
              sig_q   <= a7_s;
              cnt_q   <= CNT_W'(1);
            end else begin
              state_q <= RUN;
              cnt_q   <= '0;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_case   = fail_case_q;
  assign cycle_count = cycle_count_q;

endmodule
